mem_waitstate_ctrl: RTL and testbench

MEM_WAITSTATE_CTRL -- requirements
Module: mem_waitstate_ctrl

---
 rtl/mem_waitstate_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mem_waitstate_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_waitstate_ctrl.sv
// Memory wait-state controller: per-region programmable wait states, read latency
// tracking, byte-lane alignment and read-modify-write for word-write-only regions.
module mem_waitstate_ctrl #(
  parameter int unsigned NUM_REGIONS = 16,
  parameter int unsigned WS_W        = 4,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned DEFAULT_WS  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   cpu_addr,
  input  logic [31:0]                   cpu_wdata,
  input  logic [1:0]                    cpu_width,
  input  logic                          cpu_read,
  input  logic                          cpu_write,
  output logic [31:0]                   cpu_rdata,
  output logic                          cpu_ok,
  input  logic [NUM_REGIONS*WS_W-1:0]   ws_cfg,
  input  logic                          ws_load,
  input  logic [NUM_REGIONS-1:0]        rmw_en,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  output logic [3:0]                    mem_be,
  output logic                          mem_rd,
  output logic                          mem_wren,
  input  logic [31:0]                   mem_rdata
);

  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {StIdle, StWait, StAcc, StLat, StMerge, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        width_q, width_d;
  logic              write_q, write_d;
  logic              rmw_q, rmw_d;
  logic              rot_q, rot_d;
  logic [WS_W-1:0]   ws_cnt_q, ws_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0]       cap_q, cap_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [WS_W-1:0]   ws_q [NUM_REGIONS];

  logic [3:0]        req_region;
  logic [1:0]        req_width;
  logic              req_narrow;
  logic [WS_W-1:0]   sel_ws;
  logic              sel_rmw;

  logic [4:0]        sh;
  logic [31:0]       width_mask;
  logic [3:0]        be_base;
  logic [31:0]       lane_data;
  logic [31:0]       lane_mask;
  logic [63:0]       rd_dbl;
  logic [31:0]       rd_aligned;

  assign req_region = cpu_addr[27:24];
  assign req_width  = (cpu_width == 2'd3) ? 2'd2 : cpu_width;
  assign req_narrow = (req_width != 2'd2);

  // Region lookup; indices at or above NUM_REGIONS fall through to ws 0, no RMW.
  always_comb begin
    sel_ws  = '0;
    sel_rmw = 1'b0;
    for (int i = 0; i < int'(NUM_REGIONS); i++) begin
      if (int'(req_region) == i) begin
        sel_ws  = ws_q[i];
        sel_rmw = rmw_en[i];
      end
    end
  end

  // Lane alignment helpers derived from the latched transaction.
  always_comb begin
    sh = {addr_q[1:0], 3'b000};
    unique case (width_q)
      2'd0:    begin width_mask = 32'h0000_00FF; be_base = 4'b0001; end
      2'd1:    begin width_mask = 32'h0000_FFFF; be_base = 4'b0011; end
      default: begin width_mask = 32'hFFFF_FFFF; be_base = 4'b1111; end
    endcase
    lane_data = wdata_q << sh;
    lane_mask = width_mask << sh;
    rd_dbl    = {mem_rdata, mem_rdata} >> sh;
    // Rotate for word / RMW-region reads, otherwise shift down and zero-extend.
    rd_aligned = rot_q ? rd_dbl[31:0] : ((mem_rdata >> sh) & width_mask);
  end

  // Wait-state registers; ws_load only affects future counter loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGIONS); i++) ws_q[i] <= WS_W'(DEFAULT_WS);
    end else if (ws_load) begin
      for (int i = 0; i < int'(NUM_REGIONS); i++) ws_q[i] <= ws_cfg[i*WS_W +: WS_W];
    end
  end

  // FSM and transaction state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      width_q   <= '0;
      write_q   <= 1'b0;
      rmw_q     <= 1'b0;
      rot_q     <= 1'b0;
      ws_cnt_q  <= '0;
      lat_cnt_q <= '0;
      cap_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      width_q   <= width_d;
      write_q   <= write_d;
      rmw_q     <= rmw_d;
      rot_q     <= rot_d;
      ws_cnt_q  <= ws_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state logic: accept, wait, access, latency, merge, complete.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    width_d   = width_q;
    write_d   = write_q;
    rmw_d     = rmw_q;
    rot_d     = rot_q;
    ws_cnt_d  = ws_cnt_q;
    lat_cnt_d = lat_cnt_q;
    cap_d     = cap_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_read || cpu_write) begin
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          width_d  = req_width;
          write_d  = cpu_write;
          rmw_d    = cpu_write && req_narrow && sel_rmw;
          rot_d    = !req_narrow || sel_rmw;
          ws_cnt_d = sel_ws;
          state_d  = (sel_ws != '0) ? StWait : StAcc;
        end
      end
      StWait: begin
        if (ws_cnt_q == WS_W'(1)) state_d = StAcc;
        else                      ws_cnt_d = ws_cnt_q - WS_W'(1);
      end
      StAcc: begin
        if (!write_q || rmw_q) begin
          lat_cnt_d = LAT_W'(RD_LAT);
          state_d   = StLat;
        end else begin
          state_d = StDone;
        end
      end
      StLat: begin
        if (lat_cnt_q == LAT_W'(1)) begin
          cap_d = mem_rdata;
          if (write_q) begin
            state_d = StMerge;
          end else begin
            rdata_d = rd_aligned;
            state_d = StDone;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      StMerge: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from the registered state; strobes are mutually exclusive.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wren  = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    cpu_ok    = 1'b0;
    unique case (state_q)
      StAcc: begin
        if (!write_q || rmw_q) begin
          mem_rd = 1'b1;
        end else begin
          mem_wren  = 1'b1;
          mem_wdata = lane_data;
          mem_be    = be_base << addr_q[1:0];
        end
      end
      StMerge: begin
        mem_wren  = 1'b1;
        mem_wdata = (lane_data & lane_mask) | (cap_q & ~lane_mask);
        mem_be    = 4'hF;
      end
      StDone:  cpu_ok = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mem_waitstate_ctrl.sv
// Scoreboard bench for mem_waitstate_ctrl: expected memory strobes and completions
// are queued when a request is driven and matched as the DUT produces them.
module tb_mem_waitstate_ctrl;

  localparam int unsigned NR  = 12;
  localparam int unsigned WSW = 4;
  localparam int unsigned RDL = 1;
  localparam int unsigned DWS = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]        cpu_width;
  logic              cpu_read, cpu_write, cpu_ok;
  logic [NR*WSW-1:0] ws_cfg;
  logic              ws_load;
  logic [NR-1:0]     rmw_en;
  logic [31:0]       mem_addr, mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic [3:0]        mem_be;
  logic              mem_rd, mem_wren;

  always #5 clk = ~clk;

  mem_waitstate_ctrl #(
    .NUM_REGIONS (NR),
    .WS_W        (WSW),
    .RD_LAT      (RDL),
    .DEFAULT_WS  (DWS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_width (cpu_width),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .cpu_ok    (cpu_ok),
    .ws_cfg    (ws_cfg),
    .ws_load   (ws_load),
    .rmw_en    (rmw_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rd    (mem_rd),
    .mem_wren  (mem_wren),
    .mem_rdata (mem_rdata)
  );

  // Memory model: data valid the cycle after mem_rd, byte-enabled writes.
  logic [31:0] mem [64] = '{default: 32'h0};
  logic        pre_we  = 1'b0;
  int          pre_idx = 0;
  logic [31:0] pre_val = '0;

  function automatic int midx(input logic [31:0] a);
    return int'({a[27:24], a[3:2]});
  endfunction

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    if (mem_rd) mem_rdata <= mem[midx(mem_addr)];
    if (mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[midx(mem_addr)][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    int          kind;  // 0 mem_rd, 1 mem_wren, 2 cpu_ok
    int          at;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          chk_data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  stray    = 0;
  int  ws_model [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic void push_ev(input string tag, input int kind, input int at,
                                  input logic [31:0] addr, input logic [31:0] data,
                                  input logic [3:0] be, input bit chk_data);
    ev_t e;
    e.tag = tag; e.kind = kind; e.at = at; e.addr = addr;
    e.data = data; e.be = be; e.chk_data = chk_data;
    exp_q.push_back(e);
  endfunction

  // Monitor: sampled on the falling edge, matched in order against the queue.
  always @(negedge clk) begin
    int   nact;
    int   kind_got;
    ev_t  e;
    if (!rst) begin
      nact = int'(mem_rd) + int'(mem_wren) + int'(cpu_ok);
      if (nact > 1) check_eq("strobe_exclusive", 32'(nact), 32'd1);
      if (nact >= 1) begin
        if (exp_q.size() == 0) begin
          stray++;
          check_eq("unexpected_event", {29'b0, mem_rd, mem_wren, cpu_ok}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          kind_got = mem_rd ? 0 : (mem_wren ? 1 : 2);
          check_eq({e.tag, "_kind"}, 32'(kind_got), 32'(e.kind));
          check_eq({e.tag, "_cycle"}, 32'(cyc), 32'(e.at));
          if (e.kind != 2) check_eq({e.tag, "_addr"}, mem_addr, e.addr);
          if (e.kind == 1) begin
            check_eq({e.tag, "_wdata"}, mem_wdata, e.data);
            check_eq({e.tag, "_be"}, {28'b0, mem_be}, {28'b0, e.be});
          end
          if (e.kind == 2 && e.chk_data) check_eq({e.tag, "_rdata"}, cpu_rdata, e.data);
        end
      end
    end
  end

  task automatic preset(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = midx(a); pre_val = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic model_from_cfg();
    for (int i = 0; i < 16; i++)
      ws_model[i] = (i < int'(NR)) ? int'(ws_cfg[i*WSW +: WSW]) : 0;
  endtask

  task automatic load_ws(input int r, input int v);
    @(negedge clk);
    ws_cfg[r*WSW +: WSW] = WSW'(v);
    ws_load = 1'b1;
    @(negedge clk);
    ws_load = 1'b0;
    model_from_cfg();
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_cpu_ok"},   {31'b0, cpu_ok}, 32'd0);
    check_eq({tag, "_mem_rd"},   {31'b0, mem_rd}, 32'd0);
    check_eq({tag, "_mem_wren"}, {31'b0, mem_wren}, 32'd0);
    check_eq({tag, "_mem_be"},   {28'b0, mem_be}, 32'd0);
    check_eq({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    check_eq({tag, "_mem_addr"},  mem_addr, 32'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // Drive one request, queue its expected events, and wait for them to drain.
  task automatic run_txn(input string tag, input bit rd, input bit wr, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] wd, input int mid_ws);
    int          r, ws, nb, off, base;
    bit          rmwb, rot;
    logic [31:0] old, res, dat;
    logic [3:0]  be;
    r    = int'(a[27:24]);
    ws   = (r < int'(NR)) ? ws_model[r] : 0;
    rmwb = (r < int'(NR)) ? rmw_en[r] : 1'b0;
    nb   = (w == 2'd0) ? 1 : ((w == 2'd1) ? 2 : 4);
    off  = int'(a[1:0]);
    old  = mem[midx(a)];
    @(negedge clk);
    base = cyc;
    cpu_addr = a; cpu_wdata = wd; cpu_width = w; cpu_read = rd; cpu_write = wr;
    if (!wr) begin
      rot = (nb == 4) || rmwb;
      res = '0;
      for (int i = 0; i < 4; i++) begin
        if (rot) res[8*i +: 8] = old[8*((i + off) % 4) +: 8];
        else if (i < nb && i + off < 4) res[8*i +: 8] = old[8*(i + off) +: 8];
      end
      push_ev({tag, "_rd"}, 0, base + ws + 1, {a[31:2], 2'b00}, '0, '0, 1'b0);
      push_ev({tag, "_ok"}, 2, base + ws + int'(RDL) + 2, '0, res, '0, 1'b1);
    end else if (nb < 4 && rmwb) begin
      dat = old;
      for (int n = 0; n < nb; n++)
        if (off + n < 4) dat[8*(off + n) +: 8] = wd[8*n +: 8];
      push_ev({tag, "_rd"}, 0, base + ws + 1, {a[31:2], 2'b00}, '0, '0, 1'b0);
      push_ev({tag, "_wr"}, 1, base + ws + int'(RDL) + 2, {a[31:2], 2'b00}, dat, 4'hF, 1'b0);
      push_ev({tag, "_ok"}, 2, base + ws + int'(RDL) + 3, '0, '0, '0, 1'b0);
    end else begin
      dat = '0; be = '0;
      for (int n = 0; n < nb; n++) begin
        if (off + n < 4) begin
          dat[8*(off + n) +: 8] = wd[8*n +: 8];
          be[off + n] = 1'b1;
        end
      end
      push_ev({tag, "_wr"}, 1, base + ws + 1, {a[31:2], 2'b00}, dat, be, 1'b0);
      push_ev({tag, "_ok"}, 2, base + ws + 2, '0, '0, '0, 1'b0);
    end
    @(negedge clk);
    // Scramble requester inputs after acceptance; the latched values must win.
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = ~a; cpu_wdata = ~wd; cpu_width = ~w;
    if (mid_ws >= 0) begin
      ws_cfg[r*WSW +: WSW] = WSW'(mid_ws);
      ws_load = 1'b1;
      @(negedge clk);
      ws_load = 1'b0;
      model_from_cfg();
    end
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check_eq({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int stray0;
    rst = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_width = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    ws_load = 1'b0;
    rmw_en = '0;
    rmw_en[2] = 1'b1;
    for (int i = 0; i < int'(NR); i++) ws_cfg[i*WSW +: WSW] = WSW'(DWS);
    model_from_cfg();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Word read, ws 2.
    load_ws(3, 2);
    preset(32'h0300_0004, 32'hCAFE_F00D);
    run_txn("word_rd_ws2", 1'b1, 1'b0, 2'd2, 32'h0300_0004, '0, -1);

    // Narrow write into an RMW region, ws 0.
    load_ws(2, 0);
    preset(32'h0200_0000, 32'h1122_3344);
    run_txn("rmw_byte_wr", 1'b0, 1'b1, 2'd0, 32'h0200_0001, 32'h0000_00AB, -1);
    check_eq("rmw_byte_mem", mem[midx(32'h0200_0000)], 32'h1122_AB44);

    // Plain half write.
    run_txn("half_wr", 1'b0, 1'b1, 2'd1, 32'h0600_0002, 32'h0000_BEEF, -1);
    check_eq("half_wr_mem", mem[midx(32'h0600_0000)], 32'hBEEF_0000);

    // Rotated word read and zero-extended byte read.
    preset(32'h0300_0000, 32'h1122_3344);
    run_txn("rot_word_rd", 1'b1, 1'b0, 2'd2, 32'h0300_0001, '0, -1);
    check_eq("rot_word_val", cpu_rdata, 32'h4411_2233);
    run_txn("byte_rd", 1'b1, 1'b0, 2'd0, 32'h0300_0001, '0, -1);
    repeat (3) @(negedge clk);
    check_eq("byte_rd_hold", cpu_rdata, 32'h0000_0033);

    // Narrow read from an RMW region rotates; half RMW write at offset 2.
    run_txn("rmw_byte_rd", 1'b1, 1'b0, 2'd0, 32'h0200_0003, '0, -1);
    run_txn("rmw_half_wr", 1'b0, 1'b1, 2'd1, 32'h0200_0002, 32'h0000_5566, -1);
    check_eq("rmw_half_mem", mem[midx(32'h0200_0000)], 32'h5566_AB44);

    // Region beyond NUM_REGIONS: ws 0, no RMW.
    run_txn("bad_region_wr", 1'b0, 1'b1, 2'd0, 32'h0E00_0003, 32'h0000_0077, -1);

    // Read+write with width 3 is a word write; ws_load in WAIT leaves the count alone.
    load_ws(7, 4);
    run_txn("rw_width3", 1'b1, 1'b1, 2'd3, 32'h0700_0008, 32'h1234_5678, 1);
    run_txn("after_reload", 1'b1, 1'b0, 2'd2, 32'h0700_0008, '0, -1);

    // Reset during WAIT of a write aborts it.
    load_ws(5, 3);
    preset(32'h0500_0000, 32'hA5A5_5A5A);
    @(negedge clk);
    cpu_addr = 32'h0500_0000; cpu_wdata = 32'hDEAD_BEEF; cpu_width = 2'd2; cpu_write = 1'b1;
    @(negedge clk);
    cpu_write = 1'b0;
    @(negedge clk);
    stray0 = stray;
    rst = 1'b1;
    #1;
    check_reset("abort_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) ws_model[i] = (i < int'(NR)) ? int'(DWS) : 0;
    repeat (10) @(negedge clk);
    check_eq("abort_no_events", 32'(stray - stray0), 32'd0);
    check_eq("abort_mem_kept", mem[midx(32'h0500_0000)], 32'hA5A5_5A5A);
    run_txn("post_reset_wr", 1'b0, 1'b1, 2'd2, 32'h0500_0000, 32'h0BAD_F00D, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
